// File: rtl/univ_register_pkg.sv
// Shared op codes, FSM states and op classification for univ_register.
// Honours UNIV_REGISTER_ASR_EN: when undefined, op 110 is not a shift op.
package univ_register_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_ROTL  = 3'b100,
    OP_ROTR  = 3'b101,
    OP_ASR   = 3'b110,
    OP_CLEAR = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that move one bit per step and may therefore be run for N steps.
  function automatic logic is_shift_op(input op_e op);
    logic r;
    r = 1'b0;
    case (op)
      OP_SHL, OP_SHR, OP_ROTL, OP_ROTR: r = 1'b1;
`ifdef UNIV_REGISTER_ASR_EN
      OP_ASR: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/univ_register_if.sv
// Control/data bundle for univ_register; master drives the request side.
interface univ_register_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic [2:0]       op;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             ser_in;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output op, start, amount, ser_in, data_in,
    input  data_out, ser_out, busy, done
  );

  modport slave (
    input  op, start, amount, ser_in, data_in,
    output data_out, ser_out, busy, done
  );
endinterface

// File: rtl/univ_register_shift_step.sv
// One-bit shift/rotate step shared by single-cycle and run paths.
// ASR step exists only when UNIV_REGISTER_ASR_EN is defined.
module shift_step
  import univ_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] d_next,
  output logic             out_bit,
  output logic             out_upd
);

  always_comb begin
    d_next  = d;
    out_bit = d[0];
    out_upd = 1'b0;
    case (op)
      OP_SHL: begin
        d_next  = {d[WIDTH-2:0], ser_in};
        out_bit = d[WIDTH-1];
        out_upd = 1'b1;
      end
      OP_SHR: begin
        d_next  = {ser_in, d[WIDTH-1:1]};
        out_upd = 1'b1;
      end
      OP_ROTL: begin
        d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
        out_bit = d[WIDTH-1];
        out_upd = 1'b1;
      end
      OP_ROTR: begin
        d_next  = {d[0], d[WIDTH-1:1]};
        out_upd = 1'b1;
      end
`ifdef UNIV_REGISTER_ASR_EN
      OP_ASR: begin
        d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
        out_upd = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_register.sv
// Universal register: load/clear/shift/rotate plus a multi-step run sequencer.
// Optional arithmetic shift right via UNIV_REGISTER_ASR_EN.
module univ_register
  import univ_register_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input logic            clk,
  input logic            rst,
  univ_register_if.slave bus
);

  state_e           state;
  op_e              run_op;
  op_e              op_live;
  op_e              step_op;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_d;
  logic             ser_q;
  logic             busy_q;
  logic             done_q;
  logic             step_bit;
  logic             step_upd;

  always_comb begin
    op_live = op_e'(bus.op);
    step_op = (state == ST_RUN) ? run_op : op_live;
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (step_op),
    .d       (data_q),
    .ser_in  (bus.ser_in),
    .d_next  (step_d),
    .out_bit (step_bit),
    .out_upd (step_upd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      run_op <= OP_HOLD;
      cnt    <= '0;
      data_q <= '0;
      ser_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && is_shift_op(op_live)) begin
            run_op <= op_live;
            cnt    <= bus.amount;
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end else begin
            case (op_live)
              OP_LOAD:  data_q <= bus.data_in;
              OP_CLEAR: data_q <= '0;
              default: begin
                data_q <= step_d;
                if (step_upd) ser_q <= step_bit;
              end
            endcase
          end
        end
        ST_RUN: begin
          // The zero-count edge is a dedicated exit cycle, so amount=0 still costs one busy cycle.
          if (cnt != '0) begin
            data_q <= step_d;
            if (step_upd) ser_q <= step_bit;
            cnt <= cnt - 1'b1;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_out = data_q;
  assign bus.ser_out  = ser_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
